enigma_ctrl: RTL

Character-stream controller that drives a chain of N_STAGES rotor blocks through their valid/done interface, sitting between the host byte stream and the rotor instances. It loads rotor settings, issues one character at a time to each stage in encode or decode order, collects each stage result, and steps the rotors odometer-style after every enciphered letter. It presents ready/valid byte handshakes to the host on both input and output.

---
 rtl/enigma_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/enigma_ctrl.sv
// Character-stream controller for a chain of rotor stages: loads settings,
// routes each letter through the stages in encode or decode order and steps the rotors.
module enigma_ctrl #(
    parameter int N_STAGES = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_set,
    input  logic                  cfg_dec,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_err,
    output logic                  busy,
    output logic [N_STAGES-1:0]   rot_set,
    output logic                  rot_dec,
    output logic [N_STAGES-1:0]   rot_valid,
    output logic [7:0]            rot_din,
    output logic [N_STAGES-1:0]   rot_en,
    input  logic [8*N_STAGES-1:0] rot_dout,
    input  logic [N_STAGES-1:0]   rot_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_STEP  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam int             IW       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(N_STAGES - 1);
    localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= 8'd65) && (c <= 8'd90);
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [7:0]                cur_r;
    logic [IW-1:0]             idx_r;
    logic [7:0]                wait_cnt_r;
    logic [N_STAGES-1:0][4:0]  sc_r;
    logic                      dec_r;
    logic [7:0]                out_data_r;
    logic                      out_err_r;
    logic                      done_s;
    logic [7:0]                dout_sel_s;
    logic                      last_s;
    logic [IW-1:0]             idx_nxt_s;
    logic [N_STAGES-1:0]       carry_s;

    // Select the result and done flag of the stage currently being served
    always_comb begin
        done_s     = 1'b0;
        dout_sel_s = 8'h00;
        for (int k = 0; k < N_STAGES; k++) begin
            if (idx_r == IW'(k)) begin
                done_s     = rot_done[k];
                dout_sel_s = rot_dout[8*k +: 8];
            end else begin
                done_s     = done_s;
                dout_sel_s = dout_sel_s;
            end
        end
    end

    // Stage sequencing: decode walks the chain backwards
    always_comb begin
        if (dec_r) begin
            last_s    = (idx_r == {IW{1'b0}});
            idx_nxt_s = idx_r - {{(IW-1){1'b0}}, 1'b1};
        end else begin
            last_s    = (idx_r == IDX_LAST);
            idx_nxt_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
        end
    end

    // Odometer carry: stage k steps only when every lower stage sits at 25
    always_comb begin
        carry_s = {N_STAGES{1'b0}};
        for (int k = 0; k < N_STAGES; k++) begin
            carry_s[k] = 1'b1;
            for (int j = 0; j < k; j++) begin
                carry_s[k] = carry_s[k] & (sc_r[j] == 5'd25);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cfg_set) begin
                    state_nxt_s = S_CFG;
                end else if (in_valid) begin
                    state_nxt_s = is_upper(in_data) ? S_ISSUE : S_OUT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CFG:   state_nxt_s = S_IDLE;
            S_ISSUE: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (done_s) begin
                    state_nxt_s = last_s ? S_STEP : S_ISSUE;
                end else if (wait_cnt_r == TMO_LAST) begin
                    state_nxt_s = S_OUT;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_STEP:  state_nxt_s = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode: strobes are Moore outputs of the one-cycle states
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        rot_set   = {N_STAGES{1'b0}};
        rot_valid = {N_STAGES{1'b0}};
        rot_en    = {N_STAGES{1'b0}};
        rot_din   = 8'h00;
        case (state_r)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_CFG:   rot_set = {N_STAGES{1'b1}};
            S_ISSUE: begin
                rot_valid[idx_r] = 1'b1;
                rot_din          = cur_r;
            end
            S_WAIT:  rot_din = cur_r;
            S_STEP:  rot_en = carry_s;
            S_OUT:   out_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Datapath: character, stage index, wait counter, step counters, results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_r      <= 8'h00;
            idx_r      <= {IW{1'b0}};
            wait_cnt_r <= 8'd0;
            sc_r       <= '0;
            dec_r      <= 1'b0;
            out_data_r <= 8'h00;
            out_err_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!cfg_set && in_valid) begin
                        cur_r <= in_data;
                        idx_r <= dec_r ? IDX_LAST : {IW{1'b0}};
                        if (!is_upper(in_data)) begin
                            out_data_r <= in_data;
                            out_err_r  <= 1'b0;
                        end
                    end
                end
                S_CFG: begin
                    dec_r <= cfg_dec;
                    sc_r  <= '0;
                end
                S_ISSUE: wait_cnt_r <= 8'd0;
                S_WAIT: begin
                    if (done_s) begin
                        cur_r <= dout_sel_s;
                        if (!last_s) begin
                            idx_r <= idx_nxt_s;
                        end
                    end else if (wait_cnt_r == TMO_LAST) begin
                        out_data_r <= 8'h3F;
                        out_err_r  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                S_STEP: begin
                    for (int k = 0; k < N_STAGES; k++) begin
                        if (carry_s[k]) begin
                            sc_r[k] <= (sc_r[k] == 5'd25) ? 5'd0 : sc_r[k] + 5'd1;
                        end
                    end
                    out_data_r <= cur_r;
                    out_err_r  <= 1'b0;
                end
                default: cur_r <= cur_r;
            endcase
        end
    end

    assign rot_dec  = dec_r;
    assign out_data = out_data_r;
    assign out_err  = out_err_r;

endmodule
